iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (WIDTH >= 4, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount field width taken from B.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port alu_op  input  3  operation code.
REQ-010 SHALL have port out_valid  output  1  result/flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port carry  output  1  registered carry flag.
REQ-014 SHALL have port zero  output  1  registered zero flag (result == 0).

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 SHALL accept a request on a rising edge with in_valid && in_ready, capturing a, b and alu_op internally; later input changes have no effect.
REQ-017 SHALL decode alu_op: 000 ADD, 001 ADC (A+B+carry flag), 010 NAND, 011 SUB (A-B), 100 XOR, 101 MUL (low WIDTH bits of A*B), 110 SLL (A << b[SHW-1:0]), 111 PASS (result = A).
REQ-018 SHALL complete ADD, ADC, NAND, SUB, XOR, PASS in one cycle: IDLE -> DONE on the accepting edge.
REQ-019 SHALL compute MUL by iterative shift-add, one multiplier bit per cycle: IDLE -> EXEC, exactly WIDTH edges in EXEC, then DONE.
REQ-020 SHALL compute SLL one bit position per cycle in EXEC for b[SHW-1:0] cycles; a zero shift amount goes IDLE -> DONE directly.
REQ-021 SHALL set carry: ADD/ADC = carry-out of bit WIDTH-1; SUB = 1 when no borrow (A >= B); MUL = 1 when the high WIDTH bits of the full product are nonzero; SLL = last bit shifted out (0 for zero shift); NAND/XOR/PASS = 0.
REQ-022 SHALL set zero = 1 exactly when the final result is all zeros, for every op.
REQ-023 SHALL update result, carry and zero only on entry to DONE and hold them stable in DONE and IDLE until the next completion.
REQ-024 SHALL hold DONE while out_ready is low; DONE -> IDLE on the edge with out_ready high; no new request is accepted in that same edge.
REQ-025 SHALL make ADC use the carry flag as it stands at the accepting edge (flag of the previous completed op).
REQ-026 SHALL ignore in_valid in EXEC and DONE (no queueing).

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, result 0, carry 0, zero 0, out_valid 0, iteration counter 0, independent of clk.
REQ-028 SHALL abort any MUL/SLL in progress when reset asserts mid-operation, producing no out_valid for it.
REQ-029 SHALL assert in_ready on the first cycle after rst_n deasserts.

Structure
REQ-030 SHALL place alu_op encodings and the FSM state enum in shared package alu_pkg.
REQ-031 SHALL implement the shift-add multiplier datapath as sub-module alu_mul_iter (start, operands, done, product, overflow), instantiated once.
REQ-032 SHALL contain no $display or other simulation-only statements in synthesisable RTL.

Verification (WIDTH=16)
REQ-033 SHALL cover ADD a=0xFFFF b=0x0001 -> out_valid 1 cycle after accept, result 0x0000, carry 1, zero 1; then ADC a=0x0001 b=0x0001 -> result 0x0003, carry 0, zero 0.
REQ-034 SHALL cover SUB 5-5 -> 0x0000, carry 1, zero 1; SUB 3-5 -> 0xFFFE, carry 0, zero 0; NAND 0xFFFF,0xFFFF -> 0x0000, carry 0, zero 1.
REQ-035 SHALL cover MUL 0x0100*0x0100 -> out_valid exactly 16 cycles after accept, result 0x0000, carry 1, zero 1; MUL 0x0003*0x0005 -> 0x000F, carry 0.
REQ-036 SHALL cover SLL a=0x8001 b=0x0001 -> 0x0002, carry 1, 1 EXEC cycle; b=0x0000 -> 0x8001 in 1 cycle, carry 0.
REQ-037 SHALL cover out_ready low 3 cycles in DONE -> result/flags stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-038 SHALL cover rst_n low at EXEC cycle 8 of a MUL -> outputs 0 immediately, no out_valid, in_ready 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu: operation encodings and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_NAND = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SLL  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (async active-low); start_i loads a_i/b_i and processes
// bit 0 on the same edge; done_o pulses for one cycle once all WIDTH bits are
// consumed, with product_o (low WIDTH bits) and overflow_o (high half nonzero)
// valid from that cycle until the next start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic             overflow_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    acc_q, mcand_q, acc_step;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, ovf_q;

  // Partial-product accumulation for the current multiplier bit.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Datapath registers; cnt_q counts bits already consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= b_i[0] ? PW'(a_i) : '0;
        mcand_q  <= PW'(a_i) << 1;
        mplier_q <= b_i >> 1;
        cnt_q    <= CW'(1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          ovf_q  <= |acc_step[PW-1:WIDTH];
        end
      end
    end
  end

  assign done_o     = done_q;
  assign product_o  = acc_q[WIDTH-1:0];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake
// with operands a, b and alu_op; out_valid/out_ready result handshake with
// result, carry and zero held from completion until the next completion.
// Single-cycle ops finish on the accepting edge; MUL takes WIDTH cycles in
// EXEC, SLL takes one cycle per shift position.
module iter_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d, op_in;
  logic [WIDTH-1:0] result_q, result_d, sh_q, sh_d;
  logic             carry_q, carry_d, zero_q, zero_d;
  logic [SHW-1:0]   cnt_q, cnt_d, shamt;
  logic             upd, mul_start, mul_done, mul_ovf;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH:0]   add_sum, adc_sum, sub_sum;

  assign op_in = alu_op_e'(alu_op);
  assign shamt = b[SHW-1:0];

  // Carry-out sums; SUB via A + ~B + 1 so the carry-out means "no borrow".
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign adc_sum = add_sum + (WIDTH+1)'(carry_q);
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod),
    .overflow_o(mul_ovf)
  );

  // Controller state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and result computation; flags change only when upd is set.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    upd       = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op_in;
          state_d = ST_DONE;
          upd     = 1'b1;
          case (op_in)
            OP_ADD:  {carry_d, result_d} = add_sum;
            OP_ADC:  {carry_d, result_d} = adc_sum;
            OP_NAND: begin result_d = ~(a & b); carry_d = 1'b0; end
            OP_SUB:  {carry_d, result_d} = sub_sum;
            OP_XOR:  begin result_d = a ^ b;    carry_d = 1'b0; end
            OP_PASS: begin result_d = a;        carry_d = 1'b0; end
            OP_MUL: begin
              mul_start = 1'b1;
              state_d   = ST_EXEC;
              upd       = 1'b0;
            end
            OP_SLL: begin
              if (shamt == '0) begin
                result_d = a;
                carry_d  = 1'b0;
              end else begin
                sh_d    = a;
                cnt_d   = shamt;
                state_d = ST_EXEC;
                upd     = 1'b0;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            result_d = mul_prod;
            carry_d  = mul_ovf;
            upd      = 1'b1;
            state_d  = ST_DONE;
          end
        end else begin
          // One position per cycle; the final step's shifted-out bit is the carry.
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d = {sh_q[WIDTH-2:0], 1'b0};
            carry_d  = sh_q[WIDTH-1];
            upd      = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (upd) zero_d = (result_d == '0);
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=16): directed corner cases plus
// random operations checked against an arithmetic reference model.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int n_pass  = 0;
  int n_total = 0;
  logic model_c = 1'b0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain wide arithmetic; cyc = clock edges after the accepting edge.
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                 input logic cin, output logic [15:0] r, output logic c,
                                 output int cyc);
    longint unsigned w;
    int n;
    cyc = 0;
    c   = 1'b0;
    case (op)
      3'd0: begin w = 64'(x) + 64'(y);               r = w[15:0]; c = w[16]; end
      3'd1: begin w = 64'(x) + 64'(y) + 64'(cin);    r = w[15:0]; c = w[16]; end
      3'd2: r = ~(x & y);
      3'd3: begin r = x - y; c = (x >= y); end
      3'd4: r = x ^ y;
      3'd5: begin w = 64'(x) * 64'(y); r = w[15:0]; c = (w >> 16) != 0; cyc = 16; end
      3'd6: begin n = int'(y[3:0]); w = 64'(x) << n; r = w[15:0]; c = w[16]; cyc = n; end
      default: r = x;
    endcase
  endfunction

  // Issue one op, measure latency, check outputs, hold DONE for `hold` cycles, release.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] x,
                        input logic [15:0] y, input int hold);
    logic [15:0] er;
    logic ec;
    int ecyc, cyc;
    ref_op(op, x, y, model_c, er, ec, ecyc);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_op = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); alu_op = 3'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(ecyc));
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".carry"}, 64'(carry), 64'(ec));
    chk({tag, ".zero"}, 64'(zero), 64'(er == 16'h0));
    model_c = ec;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_flags"}, {45'd0, result, carry, zero}, {45'd0, er, ec, er == 16'h0});
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    // in_valid held high across the release edge must not start a new op.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, ".rel_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rel_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".rel_flags"}, {45'd0, result, carry, zero}, {45'd0, er, ec, er == 16'h0});
  endtask

  initial begin
    logic [15:0] x, y;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_op = '0;
    #23;
    chk("reset.outs", {60'd0, result == 16'h0, carry, zero, out_valid}, 64'h8);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    run_op("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 0);
    run_op("adc_cin",   3'd1, 16'h0001, 16'h0001, 0);
    run_op("sub_eq",    3'd3, 16'h0005, 16'h0005, 0);
    run_op("sub_borrow",3'd3, 16'h0003, 16'h0005, 0);
    run_op("nand_ones", 3'd2, 16'hFFFF, 16'hFFFF, 0);
    run_op("mul_ovf",   3'd5, 16'h0100, 16'h0100, 0);
    run_op("mul_small", 3'd5, 16'h0003, 16'h0005, 0);
    run_op("sll_one",   3'd6, 16'h8001, 16'h0001, 0);
    run_op("sll_zero",  3'd6, 16'h8001, 16'h0000, 0);
    run_op("sll_max",   3'd6, 16'h0003, 16'h000F, 1);
    run_op("xor_hold3", 3'd4, 16'hA5A5, 16'h0FF0, 3);
    run_op("pass_zero", 3'd7, 16'h0000, 16'h1234, 0);

    for (int k = 0; k < 60; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      if ($urandom_range(0, 3) == 0) y = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
      run_op("rand", 3'($urandom_range(0, 7)), x, y, int'($urandom_range(0, 2)));
    end

    // Make the held result nonzero so the reset clear is visible.
    run_op("pre_rst", 3'd7, 16'h00C3, 16'h0000, 0);
    in_valid = 1'b1; alu_op = 3'd5; a = 16'h1234; b = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort.outs", {60'd0, result == 16'h0, carry, zero, out_valid}, 64'h8);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    model_c = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort.no_valid", 64'(seen), 64'd0);
    chk("abort.ready_after", 64'(in_ready), 64'd1);
    run_op("post_rst_adc", 3'd1, 16'hFFFF, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
